// File: rtl/oldland_mem_arbiter_if.sv
// Purpose : bundles the fetch port, the load/store port and the shared memory bus
//           of the Oldland memory arbiter into one interface.
// Latency : none (wires only).
// Backpr. : requesters hold *_access and payload until their *_ack.
// Modports: slave  - the arbiter's view (receives requests and m_ack/m_data,
//                    drives acks, read data and the bus request).
//           master - the surrounding environment's view (fetch stage, data stage
//                    and memory), the mirror image of slave.
interface oldland_mem_arbiter_if;
  // fetch port
  logic        i_access;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_data;
  // load/store port
  logic        d_access;
  logic [31:0] d_addr;
  logic        d_wr_en;
  logic [31:0] d_wr_val;
  logic [3:0]  d_bytesel;
  logic        d_ack;
  logic [31:0] d_data;
  // shared memory bus
  logic        m_access;
  logic [31:0] m_addr;
  logic        m_wr_en;
  logic [31:0] m_wr_val;
  logic [3:0]  m_bytesel;
  logic        m_ack;
  logic [31:0] m_data;

  modport slave (
    input  i_access, i_addr,
    output i_ack, i_data,
    input  d_access, d_addr, d_wr_en, d_wr_val, d_bytesel,
    output d_ack, d_data,
    output m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
    input  m_ack, m_data
  );

  modport master (
    output i_access, i_addr,
    input  i_ack, i_data,
    output d_access, d_addr, d_wr_en, d_wr_val, d_bytesel,
    input  d_ack, d_data,
    input  m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
    output m_ack, m_data
  );
endinterface

// File: rtl/oldland_mem_arbiter.sv
// Purpose : shares one memory bus between instruction fetch and load/store.
// Latency : request seen in IDLE at cycle N is on the bus at N+1; ack is forwarded
//           combinationally; re-arbitration passes through one IDLE cycle.
// Backpr. : grant held until m_ack; the losing requester simply waits.
// Ports   : clk, rst (synchronous, active-high); bus (oldland_mem_arbiter_if.slave)
//           carrying the fetch port (i_*), data port (d_*) and memory bus (m_*).
// Config  : OLDLAND_ARB_RR_EN defined -> round-robin between the two ports;
//           undefined -> data has priority, with fetch forced in after
//           STARVE_LIMIT (1..15) consecutive data grants taken while fetch waited.
module oldland_mem_arbiter
`ifndef OLDLAND_ARB_RR_EN
  #(parameter int unsigned STARVE_LIMIT = 4)
`endif
(
  input  logic                   clk,
  input  logic                   rst,
  oldland_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_both;
  logic w_pick_i;   // arbitration result when both ports request in IDLE
  logic w_enter_i;
  logic w_enter_d;

  assign w_both    = bus.i_access & bus.d_access;
  assign w_enter_i = (r_state == IDLE) & (w_next == GRANT_I);
  assign w_enter_d = (r_state == IDLE) & (w_next == GRANT_D);

`ifdef OLDLAND_ARB_RR_EN
  // 0 = fetch was granted last, 1 = data was granted last. Resetting to fetch
  // makes data the first winner of a simultaneous request.
  logic r_last_grant;

  assign w_pick_i = r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b0;
    end else if (w_enter_i) begin
      r_last_grant <= 1'b0;
    end else if (w_enter_d) begin
      r_last_grant <= 1'b1;
    end
  end
`else
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  // Counts data grants taken while fetch was waiting; saturates so a long run of
  // data traffic cannot wrap it back below the limit.
  logic [3:0] r_starve_cnt;

  assign w_pick_i = (r_starve_cnt >= LP_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_enter_i) begin
      r_starve_cnt <= 4'd0;
    end else if (w_enter_d && bus.i_access && (r_starve_cnt != 4'hf)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and bus/ack outputs
  always_comb begin
    w_next        = r_state;
    bus.m_access  = 1'b0;
    bus.m_addr    = 32'd0;
    bus.m_wr_en   = 1'b0;
    bus.m_wr_val  = 32'd0;
    bus.m_bytesel = 4'd0;
    bus.i_ack     = 1'b0;
    bus.d_ack     = 1'b0;

    case (r_state)
      IDLE: begin
        // m_ack seen here belongs to nobody and is ignored
        if (w_both) begin
          w_next = w_pick_i ? GRANT_I : GRANT_D;
        end else if (bus.d_access) begin
          w_next = GRANT_D;
        end else if (bus.i_access) begin
          w_next = GRANT_I;
        end
      end
      GRANT_I: begin
        bus.m_access  = 1'b1;
        bus.m_addr    = bus.i_addr;
        bus.m_bytesel = 4'b1111;
        // an ack coinciding with reset is dropped; the requester re-issues
        bus.i_ack     = bus.m_ack & ~rst;
        if (bus.m_ack) begin
          w_next = IDLE;
        end
      end
      GRANT_D: begin
        bus.m_access  = 1'b1;
        bus.m_addr    = bus.d_addr;
        bus.m_wr_en   = bus.d_wr_en;
        bus.m_wr_val  = bus.d_wr_val;
        bus.m_bytesel = bus.d_bytesel;
        bus.d_ack     = bus.m_ack & ~rst;
        if (bus.m_ack) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Both ports see the raw bus data; each qualifies it with its own ack.
  assign bus.i_data = bus.m_data;
  assign bus.d_data = bus.m_data;

endmodule
